// File: rtl/mem_access_unit_if.sv
// Memory-side handshake between the MEM stage and the data memory.
// The master drives the request; the slave answers with a one-cycle ack and load data.
interface mem_access_unit_if #(
    parameter int N = 32
);
    logic         mem_req;
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic [N-1:0] mem_rdata;
    logic         mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: issues one load/store at a time, stalls upstream until the memory acks or times out,
// and hands the results to the MEM/WB register.
module mem_access_unit #(
    parameter int N       = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid_i,
    input  logic [N-1:0]        ALU_result_i,
    input  logic [N-1:0]        Write_data_i,
    input  logic [4:0]          WriteRegister_i,
    input  logic                MemRead_i,
    input  logic                MemWrite_i,
    input  logic                MemtoReg_i,
    input  logic                RegWrite_i,
    mem_access_unit_if.master   mem,
    output logic [N-1:0]        ALU_result_o,
    output logic [N-1:0]        Read_data_o,
    output logic [4:0]          WriteRegister_o,
    output logic                MemtoReg_o,
    output logic                RegWrite_o,
    output logic                stall_o,
    output logic                misalign_err_o,
    output logic                bus_err_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  rdata_q, rdata_d;
    logic          err_q, err_d;

    logic misaligned;
    logic memOp;
    logic badOp;

    assign misaligned = (ALU_result_i[1:0] != 2'b00);
    assign memOp      = in_valid_i & (MemRead_i ^ MemWrite_i) & ~misaligned;
    // A read+write combination is rejected the same way as a misaligned address.
    assign badOp      = in_valid_i & (MemRead_i | MemWrite_i) & ((MemRead_i & MemWrite_i) | misaligned);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        rdata_d         = rdata_q;
        err_d           = err_q;
        mem.mem_req     = 1'b0;
        mem.mem_we      = 1'b0;
        mem.mem_addr    = ALU_result_i;
        mem.mem_wdata   = Write_data_i;
        ALU_result_o    = ALU_result_i;
        WriteRegister_o = WriteRegister_i;
        MemtoReg_o      = MemtoReg_i;
        RegWrite_o      = RegWrite_i;
        Read_data_o     = '0;
        stall_o         = 1'b0;
        misalign_err_o  = 1'b0;
        bus_err_o       = 1'b0;

        case (state_q)
            IDLE: begin
                if (badOp) begin
                    RegWrite_o     = 1'b0;
                    misalign_err_o = 1'b1;
                end else if (memOp) begin
                    stall_o    = 1'b1;
                    RegWrite_o = 1'b0;
                    MemtoReg_o = 1'b0;
                    cnt_d      = '0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                mem.mem_req = 1'b1;
                mem.mem_we  = MemWrite_i;
                stall_o     = 1'b1;
                RegWrite_o  = 1'b0;
                MemtoReg_o  = 1'b0;
                cnt_d       = cnt_q + 1'b1;
                if (mem.mem_ack) begin
                    rdata_d = mem.mem_rdata;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                Read_data_o = rdata_q;
                RegWrite_o  = RegWrite_i & ~err_q;
                bus_err_o   = err_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset must silence the request and write-back immediately, not at the next edge.
        if (rst) begin
            mem.mem_req    = 1'b0;
            mem.mem_we     = 1'b0;
            stall_o        = 1'b0;
            misalign_err_o = 1'b0;
            bus_err_o      = 1'b0;
            RegWrite_o     = 1'b0;
            MemtoReg_o     = 1'b0;
            Read_data_o    = '0;
        end
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be: N, default 32, data and address width; TIMEOUT, default 16, maximum cycles to wait for mem_ack.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high; the only reset.
REQ-004 in_valid  in  1  EX/MEM slot holds a real instruction.
REQ-005 ALU_result, Write_data  in  N each  memory address (or ALU result) and store data.
REQ-006 WriteRegister  in  5  destination register.
REQ-007 MemRead, MemWrite, MemtoReg, RegWrite  in  1 each  control bits from EX/MEM.
REQ-008 mem_req, mem_we  out  1 each  memory request strobe and write qualifier.
REQ-009 mem_addr, mem_wdata  out  N each  memory address and store data.
REQ-010 mem_rdata  in  N  load data, sampled only when mem_ack=1.
REQ-011 mem_ack  in  1  memory completion, one-cycle pulse.
REQ-012 ALU_result_out, Read_data  out  N each  to the MEM/WB register.
REQ-013 WriteRegister_out  out  5  to the MEM/WB register.
REQ-014 MemtoReg_out, RegWrite_out  out  1 each  to the MEM/WB register.
REQ-015 stall  out  1  holds the PC and all upstream pipeline registers.
REQ-016 misalign_err, bus_err  out  1 each  one-cycle exception pulses.

Function
REQ-017 FSM states SHALL be IDLE, REQ and DONE; the state, the cycle counter (ceil(log2(TIMEOUT)) bits), rdata_q (N bits) and err_q SHALL be registered.
REQ-018 A memory op SHALL be in_valid & (MemRead ^ MemWrite); misaligned SHALL mean ALU_result[1:0] != 0.
REQ-019 IDLE, non-memory op or in_valid=0: stall=0; outputs pass through combinationally; Read_data=0; state stays IDLE.
REQ-020 IDLE, aligned memory op: stall=1; RegWrite_out=0; MemtoReg_out=0; counter cleared; next state REQ.
REQ-021 IDLE, misaligned memory op, or MemRead & MemWrite both 1: no request; stall=0; RegWrite_out=0; misalign_err=1 for that cycle; state stays IDLE.
REQ-022 REQ: mem_req=1; mem_we=MemWrite; mem_addr=ALU_result; mem_wdata=Write_data; stall=1; outputs bubbled per REQ-020; counter increments each cycle.
REQ-023 REQ with mem_ack=1: rdata_q <= mem_rdata; err_q <= 0; next state DONE.
REQ-024 REQ, mem_ack=0 and counter = TIMEOUT-1: err_q <= 1; rdata_q <= 0; next state DONE.
REQ-025 DONE: stall=0; mem_req=0; outputs pass through; Read_data=rdata_q; RegWrite_out = RegWrite & ~err_q; bus_err=err_q; next state IDLE.
REQ-026 Load latency SHALL be (cycles from entering REQ to mem_ack) + 2; the minimum, ack in the first REQ cycle, is 3 cycles with stall high for 2.
REQ-027 mem_ack seen in IDLE or DONE SHALL be ignored.
REQ-028 The upstream stage holds its inputs stable while stall=1; the block SHALL NOT latch them.
REQ-029 Back-to-back memory ops SHALL each take the full IDLE->REQ->DONE sequence, with no overlap.

Reset
REQ-030 With reset=1, asynchronously: state=IDLE; counter=0; rdata_q=0; err_q=0; mem_req=0; stall=0; misalign_err=0; bus_err=0.
REQ-031 While reset=1, RegWrite_out and MemtoReg_out SHALL be 0 and all other outputs SHALL be combinational from the inputs as in IDLE.
REQ-032 Reset asserted in REQ or DONE SHALL abort the access; the result is discarded and no write-back occurs.

Verification
REQ-033 Load, addr 0x10, mem_ack 2 cycles after entering REQ, mem_rdata 0xDEADBEEF -> stall high 3 cycles; DONE shows Read_data 0xDEADBEEF, RegWrite_out 1.
REQ-034 Store, addr 0x20, data 0x1234, immediate ack -> mem_req, mem_we 1 cycle each; mem_addr 0x20; mem_wdata 0x1234; stall 2 cycles; RegWrite_out 0.
REQ-035 Load, addr 0x13 -> no mem_req; misalign_err 1 cycle; stall 0; RegWrite_out 0.
REQ-036 Load, ack never arrives, TIMEOUT 16 -> mem_req high 16 cycles; DONE shows bus_err 1, RegWrite_out 0, Read_data 0.
REQ-037 Reset pulsed during the 3rd REQ cycle -> mem_req and stall drop without waiting for a clock edge; late ack ignored; next ADD passes with RegWrite_out 1.
REQ-038 ADD then a load with immediate ack -> ADD passes with no stall; load takes 3 cycles; no stray mem_req.
